// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder: one request at a time, LATENCY wait states, single-cycle response.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into error responses with the store suppressed.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         count_r;
    logic               lat_write_r;
    logic [31:0]        lat_addr_r;
    logic [31:0]        lat_wdata_r;
    logic [31:0]        mem_r [DEPTH];
    logic [IDX_W-1:0]   index_s;
    logic               misalign_s;
    logic               access_s;
    logic               mem_we_s;
    logic               unused_addr_s;

    assign index_s       = lat_addr_r[IDX_W+1:2];
    assign unused_addr_s = ^{lat_addr_r[31:IDX_W+2], lat_addr_r[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_s = (lat_addr_r[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // Access edge decode; reset at the access edge aborts the store
    always_comb begin
        access_s = 1'b0;
        mem_we_s = 1'b0;
        if (reset && (state_r == WAIT) && (count_r == 4'd0)) begin
            access_s = 1'b1;
            mem_we_s = lat_write_r && !misalign_s;
        end else begin
            access_s = 1'b0;
            mem_we_s = 1'b0;
        end
    end

    // Array write port; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[index_s] <= lat_wdata_r;
        end
    end

    // Request FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            count_r     <= 4'd0;
            lat_write_r <= 1'b0;
            lat_addr_r  <= 32'd0;
            lat_wdata_r <= 32'd0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_write_r <= req_write;
                        lat_addr_r  <= req_addr;
                        lat_wdata_r <= req_wdata;
                        count_r     <= 4'(LATENCY);
                        state_r     <= WAIT;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                WAIT: begin
                    if (count_r != 4'd0) begin
                        count_r <= count_r - 4'd1;
                    end else if (access_s) begin
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
                        if (misalign_s) begin
                            rsp_rdata <= 32'd0;
                            rsp_err   <= 1'b1;
                        end else if (!lat_write_r) begin
                            rsp_rdata <= mem_r[index_s];
                        end
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    count_r   <= 4'd0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expectations come from a reference memory model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rdata = 32'd0;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: computes the response and updates model state in request order
    function automatic exp_t model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   idx;
        bit   mis;
        idx = int'(addr[9:2]);
        mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (addr[1:0] != 2'b00);
`endif
        if (mis) begin
            last_rdata = 32'd0;
            e.err = 1'b1;
        end else begin
            e.err = 1'b0;
            if (wr) model_mem[idx] = wd;
            else    last_rdata = model_mem[idx];
        end
        e.rdata = last_rdata;
        return e;
    endfunction

    // Waits (bounded) for rsp_valid; cycle 1 is the negedge right after acceptance
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_txn(input string name, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   cyc;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        sb_q.push_back(model_access(wr, addr, wd));
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL %s accept_ready: got %b want 0", name, req_ready);
        else passed++;
        wait_rsp(cyc);
        checks++;
        if (cyc !== LAT + 2) $display("FAIL %s rsp_latency: got %0d want %0d", name, cyc, LAT + 2);
        else passed++;
        checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s scoreboard: got empty queue want one entry", name);
        end else begin
            e = sb_q.pop_front();
            if (rsp_rdata !== e.rdata || rsp_err !== e.err)
                $display("FAIL %s rsp_data: got %h/%b want %h/%b", name, rsp_rdata, rsp_err, e.rdata, e.err);
            else passed++;
        end
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) $display("FAIL %s resp_state: got ready=%b busy=%b want 0/1", name, req_ready, busy);
        else passed++;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || rsp_err !== 1'b0)
            $display("FAIL %s after_resp: got valid=%b ready=%b busy=%b err=%b want 0/1/0/0", name, rsp_valid, req_ready, busy, rsp_err);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
        else passed++;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) $display("FAIL reset_rsp: got valid=%b err=%b want 0/0", rsp_valid, rsp_err);
        else passed++;
        checks++;
        if (rsp_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        last_rdata = 32'd0;
    endtask

    task automatic test_store_load();
        run_txn("st_0x10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        run_txn("ld_0x10", 1'b0, 32'h0000_0010, 32'd0);
    endtask

    task automatic test_wrap();
        run_txn("st_0x400", 1'b1, 32'h0000_0400, 32'h1111_2222);
        run_txn("ld_0x0_wrap", 1'b0, 32'h0000_0000, 32'd0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0030;
        req_wdata = 32'h0BAD_0030;
        sb_q.push_back(model_access(1'b1, 32'h0000_0030, 32'h0BAD_0030));
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) $display("FAIL b2b_first_accept: got %b want 0", req_ready);
        else passed++;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h5A5A_5A5A;
        sb_q.push_back(model_access(1'b1, 32'h0000_0020, 32'h5A5A_5A5A));
        wait_rsp(cyc);
        checks++;
        if (cyc !== LAT + 2) $display("FAIL b2b_first_latency: got %0d want %0d", cyc, LAT + 2);
        else passed++;
        e = sb_q.pop_front();
        checks++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) $display("FAIL b2b_first_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
        else passed++;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL b2b_idle: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        else passed++;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL b2b_second_accept: got %b want 0", req_ready);
        else passed++;
        wait_rsp(cyc);
        checks++;
        if (cyc !== LAT + 2) $display("FAIL b2b_second_latency: got %0d want %0d", cyc, LAT + 2);
        else passed++;
        e = sb_q.pop_front();
        checks++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) $display("FAIL b2b_second_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
        else passed++;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL b2b_done: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        else passed++;
        run_txn("ld_0x30", 1'b0, 32'h0000_0030, 32'd0);
        run_txn("ld_0x20", 1'b0, 32'h0000_0020, 32'd0);
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) $display("FAIL abort_accept: got ready=%b busy=%b want 0/1", req_ready, busy);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL abort_no_rsp: got rsp_valid seen=%b want 0", seen);
        else passed++;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_rdata !== 32'd0)
            $display("FAIL abort_outputs: got ready=%b busy=%b rdata=%h want 1/0/0", req_ready, busy, rsp_rdata);
        else passed++;
        last_rdata = 32'd0;
        run_txn("ld_0x20_after_abort", 1'b0, 32'h0000_0020, 32'd0);
    endtask

    task automatic test_misalign();
        run_txn("st_0x13", 1'b1, 32'h0000_0013, 32'h1234_5678);
        run_txn("ld_0x10_after_0x13", 1'b0, 32'h0000_0010, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom_range(0, 15), 4'h0, 8'($urandom_range(64, 255)), 2'b00};
            d = $urandom;
            run_txn($sformatf("rnd_st_%0d", i), 1'b1, a, d);
            run_txn($sformatf("rnd_ld_%0d", i), 1'b0, a, 32'd0);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
